// File: rtl/softmax_normalizer.sv
// softmax_normalizer
//   Second Softermax stage. Buffers one row of up to NUM_CHUNKS chunks of
//   unnormalized pow2 values. While chunks arrive it folds each chunk's
//   max/sum into a running max/sum (online-softmax correction). It then
//   forms 1/sum with a bit-serial restoring divider and emits the normalized
//   probabilities one chunk per beat.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input chunk handshake; in_last marks the row end
//   vec_in, max_in,       chunk pow2 values (Q1.15), chunk integer max
//   sum_in                (signed, FW fraction bits), chunk sum
//   out_valid/out_ready   output chunk handshake; out_last marks the row end
//   vec_out               normalized probabilities (OUT_FW fraction bits)
//
// state  | meaning
// ACCUM  | accept chunks, merge running max/sum
// DIVIDE | RECIP_BW-cycle restoring division 2^(RECIP_FW+ACCUM_FW)/s_run
// EMIT   | scale buffered chunks by the reciprocal, one beat per chunk
module softmax_normalizer #(
  parameter int BW         = 8,
  parameter int FW         = 2,
  parameter int POW_BW     = 16,
  parameter int POW_FW     = 15,
  parameter int ACCUM_BW   = 16,
  parameter int ACCUM_FW   = 6,
  parameter int RECIP_BW   = 16,
  parameter int RECIP_FW   = 15,
  parameter int OUT_BW     = 8,
  parameter int OUT_FW     = 7,
  parameter int VEC_SIZE   = 4,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [VEC_SIZE-1:0][POW_BW-1:0]   vec_in,
  input  logic [BW-1:0]                     max_in,
  input  logic [ACCUM_BW-1:0]               sum_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [VEC_SIZE-1:0][OUT_BW-1:0]   vec_out
);

  localparam int IW       = $clog2(NUM_CHUNKS);
  localparam int CW       = $clog2(NUM_CHUNKS + 1);
  localparam int DCW      = $clog2(RECIP_BW);
  localparam int NW       = ACCUM_BW + RECIP_BW + 1;
  localparam int PW       = POW_BW + RECIP_BW;
  localparam int SCALE_SH = POW_FW + RECIP_FW - OUT_FW;

  // Dividend 2^(RECIP_FW+ACCUM_FW), split into the part that seeds the
  // remainder and the RECIP_BW bits shifted in one per cycle.
  localparam logic [NW-1:0]       NUMER  = {{(NW-1){1'b0}}, 1'b1} << (RECIP_FW + ACCUM_FW);
  localparam logic [NW-1:0]       NUM_HI = NUMER >> RECIP_BW;
  localparam logic [RECIP_BW-1:0] NUM_LO = NUMER[RECIP_BW-1:0];

  typedef enum logic [1:0] {ACCUM, DIVIDE, EMIT} state_e;

  state_e                           state_q;
  logic [CW-1:0]                    cnt_q;
  logic [IW-1:0]                    rd_q;
  logic [BW-1:0]                    m_run_q;
  logic [ACCUM_BW-1:0]              s_run_q;
  logic [RECIP_BW-1:0]              recip_q;
  logic [ACCUM_BW-1:0]              rem_q;
  logic [RECIP_BW-1:0]              num_q;
  logic [DCW-1:0]                   div_cnt_q;
  logic                             in_ready_q;
  logic                             out_valid_q;
  logic                             out_last_q;
  logic [VEC_SIZE-1:0][OUT_BW-1:0]  vec_out_q;

  logic [VEC_SIZE-1:0][POW_BW-1:0]  vec_buf_q [NUM_CHUNKS];
  logic [BW-1:0]                    max_buf_q [NUM_CHUNKS];

  // ---------------------------------------------------------------- merge
  logic                accept;
  logic                max_gt;
  logic [BW:0]         max_diff;
  logic [BW:0]         abs_diff;
  logic [BW:0]         d_sh;
  logic [ACCUM_BW:0]   s_add;
  logic [ACCUM_BW-1:0] s_d;
  logic [BW-1:0]       m_d;
  logic                row_end;

  assign accept  = (state_q == ACCUM) && in_valid && in_ready_q;
  assign row_end = in_last || (cnt_q == CW'(NUM_CHUNKS - 1));

  always_comb begin
    max_gt   = $signed(max_in) > $signed(m_run_q);
    max_diff = {max_in[BW-1], max_in} - {m_run_q[BW-1], m_run_q};
    abs_diff = max_gt ? max_diff : -max_diff;
    d_sh     = abs_diff >> FW;
    // Whichever side had the smaller max is rescaled before the add.
    if (max_gt) s_add = {1'b0, s_run_q >> d_sh} + {1'b0, sum_in};
    else        s_add = {1'b0, s_run_q} + {1'b0, sum_in >> d_sh};
    if (cnt_q == '0) begin
      s_d = sum_in;
      m_d = max_in;
    end else begin
      s_d = s_add[ACCUM_BW] ? '1 : s_add[ACCUM_BW-1:0];
      m_d = max_gt ? max_in : m_run_q;
    end
  end

  // -------------------------------------------------------------- divider
  logic [ACCUM_BW:0] trial;
  logic              q_bit;
  logic              div_sat;

  assign trial   = {rem_q, num_q[RECIP_BW-1]};
  assign q_bit   = trial >= {1'b0, s_run_q};
  // Quotient would not fit RECIP_BW bits (also covers s_run == 0).
  assign div_sat = NUM_HI >= {{(NW-ACCUM_BW){1'b0}}, s_run_q};

  // ----------------------------------------------------------------- emit
  logic [IW-1:0]                    emit_idx;
  logic [BW-1:0]                    emit_max;
  logic [BW:0]                      emit_diff;
  logic [BW:0]                      emit_sh;
  logic                             emit_last;
  logic [VEC_SIZE-1:0][OUT_BW-1:0]  emit_vec;

  function automatic logic [OUT_BW-1:0] scale_elem(input logic [POW_BW-1:0]   pow,
                                                   input logic [BW:0]         sh,
                                                   input logic [RECIP_BW-1:0] r);
    logic [POW_BW-1:0] p;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     q;
    p    = pow >> sh;
    prod = {{RECIP_BW{1'b0}}, p} * {{POW_BW{1'b0}}, r};
    q    = prod >> SCALE_SH;
    if (q[PW-1:OUT_BW] != '0) return '1;
    return q[OUT_BW-1:0];
  endfunction

  // First load after DIVIDE reads slot rd; each accepted beat preloads rd+1.
  assign emit_idx  = out_valid_q ? rd_q + IW'(1) : rd_q;
  assign emit_max  = max_buf_q[emit_idx];
  assign emit_diff = {m_run_q[BW-1], m_run_q} - {emit_max[BW-1], emit_max};
  assign emit_sh   = emit_diff >> FW;
  assign emit_last = (CW'(emit_idx) == cnt_q - CW'(1));

  always_comb begin
    emit_vec = '0;
    for (int i = 0; i < VEC_SIZE; i++)
      emit_vec[i] = scale_elem(vec_buf_q[emit_idx][i], emit_sh, recip_q);
  end

  // --------------------------------------------------------------- buffer
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_buf_q[cnt_q[IW-1:0]] <= vec_in;
      max_buf_q[cnt_q[IW-1:0]] <= max_in;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      rd_q        <= '0;
      m_run_q     <= '0;
      s_run_q     <= '0;
      recip_q     <= '0;
      rem_q       <= '0;
      num_q       <= '0;
      div_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      vec_out_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            cnt_q   <= cnt_q + CW'(1);
            m_run_q <= m_d;
            s_run_q <= s_d;
            if (row_end) begin
              state_q    <= DIVIDE;
              in_ready_q <= 1'b0;
              div_cnt_q  <= DCW'(RECIP_BW - 1);
              rem_q      <= NUM_HI[ACCUM_BW-1:0];
              num_q      <= NUM_LO;
            end
          end
        end
        DIVIDE: begin
          rem_q   <= q_bit ? ACCUM_BW'(trial - {1'b0, s_run_q}) : ACCUM_BW'(trial);
          num_q   <= {num_q[RECIP_BW-2:0], 1'b0};
          recip_q <= {recip_q[RECIP_BW-2:0], q_bit};
          if (div_cnt_q == '0) begin
            if (div_sat) recip_q <= '1;
            state_q <= EMIT;
            rd_q    <= '0;
          end else begin
            div_cnt_q <= div_cnt_q - DCW'(1);
          end
        end
        EMIT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            vec_out_q   <= emit_vec;
            out_last_q  <= emit_last;
          end else if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              cnt_q       <= '0;
              rd_q        <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= ACCUM;
            end else begin
              rd_q       <= rd_q + IW'(1);
              vec_out_q  <= emit_vec;
              out_last_q <= emit_last;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign vec_out   = vec_out_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
// Testbench for softmax_normalizer: directed rows from the test plan plus
// randomized rows, all checked against an arithmetic reference model.
module tb_softmax_normalizer;
  localparam int VS = 4;
  localparam int NC = 4;
  localparam int RB = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 in_ready, out_valid, out_last;
  logic [VS-1:0][15:0]  vec_in = '0;
  logic [7:0]           max_in = '0;
  logic [15:0]          sum_in = '0;
  logic [VS-1:0][7:0]   vec_out;

  softmax_normalizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .vec_in(vec_in), .max_in(max_in), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Row description and model results
  int     pw [NC][VS];
  int     mx [NC];
  int     sm [NC];
  int     nch;
  bit     use_last;
  longint exp_m, exp_s, exp_r;
  int     exp_out [NC][VS];

  task automatic model_row();
    longint m, s, d, r, sh, p, q;
    m = 0; s = 0;
    for (int k = 0; k < nch; k++) begin
      if (k == 0) begin
        m = mx[0]; s = sm[0];
      end else begin
        d = ((mx[k] > m) ? (mx[k] - m) : (m - mx[k])) / 4;
        if (mx[k] > m) begin
          s = ((d >= 16) ? 0 : (s >> d)) + sm[k];
          m = mx[k];
        end else begin
          s = s + ((d >= 16) ? 0 : (longint'(sm[k]) >> d));
        end
        if (s > 65535) s = 65535;
      end
    end
    r = (s == 0) ? 65535 : (longint'(2097152) / s);
    if (r > 65535) r = 65535;
    exp_m = m; exp_s = s; exp_r = r;
    for (int k = 0; k < nch; k++) begin
      sh = (m - mx[k]) / 4;
      for (int i = 0; i < VS; i++) begin
        p = (sh >= 16) ? 0 : (longint'(pw[k][i]) >> sh);
        q = (p * r) / 64'd8388608;
        exp_out[k][i] = (q > 255) ? 255 : int'(q);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunks(input bit rnd, output int unsigned acc_cyc);
    int t;
    acc_cyc = 0;
    for (int k = 0; k < nch; k++) begin
      if (rnd) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      for (int i = 0; i < VS; i++) vec_in[i] = 16'(pw[k][i]);
      max_in  = 8'(mx[k]);
      sum_in  = 16'(sm[k]);
      in_last = (k == nch - 1) && use_last;
      t = 0;
      while (!in_ready && t < 50) begin tick(); t++; end
      if (t == 50) chk_eq("in_ready_timeout", 0, 1);
      tick();
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_row(input bit rnd, input int stall_beat, input int stall_len);
    int unsigned        e_cyc;
    int                 t, k, guard, stall_cnt;
    bit                 rdy, held;
    logic [VS-1:0][7:0] snap_vec;
    logic               snap_last;
    model_row();
    send_chunks(rnd, e_cyc);
    chk_eq("in_ready_drop", in_ready, 0);
    t = 0;
    while (!out_valid && t < 60) begin
      chk_eq("in_ready_divide", in_ready, 0);
      tick(); t++;
    end
    if (t == 60) chk_eq("out_valid_timeout", 0, 1);
    chk_eq("latency", cyc - e_cyc, RB + 1);
    chk_eq("s_run", dut.s_run_q, exp_s);
    chk_eq("recip", dut.recip_q, exp_r);
    k = 0; guard = 0; stall_cnt = 0; held = 0;
    snap_vec = '0; snap_last = 1'b0;
    while (k < nch && guard < 200) begin
      if (held) begin
        chk_eq("hold_valid", out_valid, 1);
        chk_eq("hold_vec", vec_out, snap_vec);
        chk_eq("hold_last", out_last, snap_last);
      end
      if (stall_beat == k && stall_cnt < stall_len) begin
        rdy = 1'b0; stall_cnt++;
      end else begin
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      out_ready = rdy;
      chk_eq("in_ready_emit", in_ready, 0);
      if (out_valid && rdy) begin
        for (int i = 0; i < VS; i++)
          chk_eq($sformatf("beat%0d_elem%0d", k, i), vec_out[i], exp_out[k][i]);
        chk_eq($sformatf("beat%0d_last", k), out_last, (k == nch - 1));
        k++;
        held = 0;
      end else if (out_valid) begin
        held = 1; snap_vec = vec_out; snap_last = out_last;
      end else begin
        held = 0;
        chk_eq("valid_gap", out_valid, 1);
      end
      tick();
      guard++;
    end
    if (guard == 200) chk_eq("beat_timeout", k, nch);
    out_ready = 1'b0;
    chk_eq("valid_clear", out_valid, 0);
    chk_eq("in_ready_back", in_ready, 1);
  endtask

  task automatic set_s1();
    nch = 1; use_last = 1;
    pw[0][0] = 'h8000; pw[0][1] = 'h4000; pw[0][2] = 'h2000; pw[0][3] = 'h2000;
    mx[0] = 0; sm[0] = 'h0080;
  endtask

  initial begin
    int unsigned dummy;
    bit          saw;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_out_last", out_last, 0);
    chk_eq("rst_vec_out", vec_out, 0);
    chk_eq("rst_in_ready", in_ready, 0);
    chk_eq("rst_cnt", dut.cnt_q, 0);
    rst_n = 1'b1;
    tick();
    chk_eq("in_ready_after_rst", in_ready, 1);

    // 1: single chunk
    set_s1();
    run_row(0, -1, 0);

    // 2 + 4: rising max, with 5-cycle backpressure on the second beat
    nch = 2; use_last = 1;
    for (int i = 0; i < VS; i++) begin pw[0][i] = 'h8000; pw[1][i] = 'h8000; end
    mx[0] = 0; sm[0] = 'h0100; mx[1] = 4; sm[1] = 'h0100;
    run_row(0, 1, 5);

    // 3: forced last after NUM_CHUNKS chunks
    nch = NC; use_last = 0;
    for (int k = 0; k < NC; k++) begin
      for (int i = 0; i < VS; i++) pw[k][i] = int'($urandom_range(0, 32768));
      mx[k] = 4 * k - 4; sm[k] = 'h0200 + k;
    end
    run_row(0, 2, 3);

    // 5: saturating sum
    nch = 2; use_last = 1;
    for (int i = 0; i < VS; i++) begin pw[0][i] = 'h8000; pw[1][i] = 'h8000; end
    mx[0] = 8; sm[0] = 'hC000; mx[1] = 8; sm[1] = 'hC000;
    run_row(0, -1, 0);

    // 6: reset during DIVIDE, then a clean single-chunk row
    set_s1();
    model_row();
    send_chunks(0, dummy);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_cnt", dut.cnt_q, 0);
    chk_eq("midrst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    saw = 0;
    repeat (25) begin
      tick();
      if (out_valid) saw = 1;
    end
    chk_eq("no_stale_output", saw, 0);
    chk_eq("in_ready_after_midrst", in_ready, 1);
    run_row(0, -1, 0);

    // Randomized rows
    for (int r = 0; r < 40; r++) begin
      nch = int'($urandom_range(1, NC));
      use_last = (nch < NC) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < nch; k++) begin
        for (int i = 0; i < VS; i++) pw[k][i] = int'($urandom_range(0, 32768));
        mx[k] = (int'($urandom_range(0, 31)) - 16) * 4;
        case ($urandom_range(0, 3))
          0:       sm[k] = int'($urandom_range(0, 40));
          1:       sm[k] = int'($urandom_range(32768, 65535));
          default: sm[k] = int'($urandom_range(0, 4096));
        endcase
      end
      run_row(1, int'($urandom_range(0, NC)), int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/softmax_normalizer.md
# softmax_normalizer

Second stage of the Softermax datapath. It consumes the unnormalized chunk results from the unnormalized-softmax stage, which are:

- per-chunk pow2 values,
- the chunk's integer max,
- the chunk's sum.

It buffers one row of up to NUM_CHUNKS chunks and merges the chunk max/sum pairs into a running global max and sum (the online-softmax correction). It then computes 1/sum with an iterative divider and emits the normalized probabilities one chunk per beat over a valid/ready handshake.

## Interface

Parameters:
- BW, 8: width of the max input (fixed point).
- FW, 2: fraction bits of max_in. Max values are integer-valued.
- POW_BW, 16: width of each pow value. Format is Q1.15.
- POW_FW, 15: fraction bits of each pow value.
- ACCUM_BW, 16: width of the sum input and of the running sum.
- ACCUM_FW, 6: fraction bits of the sum.
- RECIP_BW, 16: width of the reciprocal register. This is also the divider cycle count.
- RECIP_FW, 15: fraction bits of the reciprocal.
- OUT_BW, 8: width of each output probability.
- OUT_FW, 7: fraction bits of each output probability.
- VEC_SIZE, 4: number of elements per chunk.
- NUM_CHUNKS, 4: buffer depth, in chunks per row.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- in_valid, input, 1: chunk on the input bus is valid.
- in_ready, output, 1: block accepts the chunk.
- in_last, input, 1: this chunk is the final chunk of the row.
- vec_in, input, POW_BW x VEC_SIZE: pow2 values of the chunk.
- max_in, input, BW: integer max of the chunk.
- sum_in, input, ACCUM_BW: sum of the chunk.
- out_valid, output, 1: normalized chunk on the output bus is valid.
- out_ready, input, 1: downstream accepts the output chunk.
- out_last, output, 1: this output chunk is the final chunk of the row.
- vec_out, output, OUT_BW x VEC_SIZE: normalized probabilities.

## Operation

The FSM has three states: ACCUM (the reset state), DIVIDE and EMIT.

ACCUM
- in_ready=1 in this state only.
- On in_valid&&in_ready:
  - Write vec_in and max_in into buffer slot cnt, then increment cnt.
  - If cnt==0, load m_run=max_in and s_run=sum_in.
  - Otherwise compute the shift d=|max_in−m_run|>>FW.
    - If max_in>m_run: s_run=(s_run>>d)+sum_in, and m_run=max_in.
    - Otherwise: s_run=s_run+(sum_in>>d).
  - The add saturates at 2^ACCUM_BW−1. A shift d≥ACCUM_BW yields 0.
- Go to DIVIDE when in_last=1, or when the accepted chunk fills slot NUM_CHUNKS−1 (forced last).

DIVIDE
- Restoring division, one quotient bit per cycle, RECIP_BW cycles.
- Result: R = min(floor(2^(RECIP_FW+ACCUM_FW)/s_run), 2^RECIP_BW−1).
- If s_run==0, R=2^RECIP_BW−1.
- Then go to EMIT with rd=0.

EMIT
- For each element i of slot rd:
  - sh = (m_run−max[rd])>>FW.
  - p = vec[rd][i]>>sh.
  - q = (p·R)>>(POW_FW+RECIP_FW−OUT_FW), saturated to 2^OUT_BW−1.
- Results are registered into vec_out.
- out_last=1 when rd==cnt−1.
- On out_valid&&out_ready:
  - If last, clear cnt and go to ACCUM.
  - Otherwise rd++ and load the next slot's results.
- vec_out, out_last and out_valid stay stable while out_ready=0.

## Timing

- Reset (async, rst_n low) sets:
  - state=ACCUM, cnt=0, rd=0, m_run=0, s_run=0, R=0.
  - out_valid=0, out_last=0, vec_out all 0.
  - in_ready=1 one cycle after deassertion.
- Reset mid-DIVIDE or mid-EMIT aborts the row. No partial output follows.
- Input throughput is one chunk per cycle in ACCUM. The s_run/m_run merge completes in the accept cycle.
- in_ready falls in the cycle after the last-chunk accept. in_last is ignored in DIVIDE and EMIT.
- Latency: if the last chunk is accepted at edge E, then out_valid rises at edge E+RECIP_BW+1.
- Output throughput is one chunk per cycle while out_ready=1.
- The row always ends with exactly cnt output beats, where cnt is the number of chunks accepted (1..NUM_CHUNKS).
- in_ready returns to 1 in the cycle after the final output handshake.

## Test plan

1. Single chunk.
   - Stimulus: vec_in={0x8000,0x4000,0x2000,0x2000}, max_in=0, sum_in=0x0080 (2.0), in_last=1.
   - Required: R=0x4000; vec_out={64,32,16,16} with out_last=1; out_valid rises 17 cycles after the accept.
2. Two chunks with a rising max.
   - Stimulus: chunk A with all pows 0x8000, max 0, sum 0x0100; then chunk B with all pows 0x8000, max 0x04 (1.0), sum 0x0100, in_last=1.
   - Required: s_run=0x0180; R=5461; beat A={10,10,10,10}; beat B={21,21,21,21} with out_last=1.
3. Forced last.
   - Stimulus: NUM_CHUNKS chunks with in_last held at 0.
   - Required: DIVIDE entered after the 4th chunk, then 4 output beats, only the 4th with out_last=1.
4. Backpressure.
   - Stimulus: out_ready=0 for 5 cycles during EMIT in scenario 2.
   - Required: vec_out, out_last and out_valid held stable; no beat skipped or repeated; in_ready stays 0 throughout.
5. Saturation.
   - Stimulus: two chunks, each with sum 0xC000 and equal max.
   - Required: s_run=0xFFFF; R=32 (2^21/65535, floored); pow 0x8000 gives output 0.
6. Reset mid-operation.
   - Stimulus: assert rst_n=0 during DIVIDE.
   - Required: out_valid=0 immediately; cnt=0; next row (scenario 1) produces exactly the scenario 1 results.
